seq_detector_prog: RTL

Runtime-programmable serial pattern detector, generalising the fixed 12-bit detector. Pattern, active length (1..MAX_LEN) and overlap/non-overlap mode are loaded through a config port. Input bits are qualified by a valid strobe. No false detection is possible out of reset or after reconfiguration. A saturating detection counter is provided for status/debug.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_match.sv | 29 ++
 rtl/seq_detector_prog.sv | 83 ++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants, length type and mask helper for the programmable sequence detector.
package seq_det_pkg;
  localparam int MAX_LEN_DEF = 16;
  localparam logic [MAX_LEN_DEF-1:0] DEFAULT_PATTERN = 16'h0EDB;
  localparam int DEFAULT_LEN = 12;
  typedef logic [$clog2(MAX_LEN_DEF+1)-1:0] len_t;
  function automatic logic [MAX_LEN_DEF-1:0] len_mask(len_t len);
    logic [MAX_LEN_DEF-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN_DEF; i++) m[i] = (i < int'(len));
    return m;
  endfunction
endpackage

// File: rtl/seq_match.sv
// seq_match: combinational masked pattern compare qualified by fill level.
//   hist_i/x_i     : stored history and incoming bit
//   valid_i        : bit is accepted this cycle
//   pattern_i/len_i: active pattern and (clamped) length
//   fill_i         : accepted bits since last clear
//   match_o        : completing bit matches the pattern
module seq_match #(
  parameter int MAX_LEN = 16,
  parameter int LW = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist_i,
  input  logic               x_i,
  input  logic               valid_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LW-1:0]      len_i,
  input  logic [LW-1:0]      fill_i,
  output logic               match_o
);
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] cand;
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_i));
  end
  assign cand = {hist_i[MAX_LEN-2:0], x_i};
  // len 0 disables detection; also keeps len_i-1 from wrapping
  assign match_o = valid_i && (len_i != '0) && (((cand ^ pattern_i) & mask) == '0)
                   && (fill_i >= len_i - LW'(1));
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector with saturating hit counter.
//   reset          : async active-low
//   cfg_*_i        : pattern / length / overlap load, applied when cfg_we_i
//   x_valid_i, x_i : qualified serial input
//   cnt_clr_i      : clears the detection counter
//   det_o          : one-cycle detection pulse, one clock after the completing bit
//   det_cnt_o      : saturating detection count
//   cfg_len_o      : clamped length in use
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEFAULT_PATTERN),
  parameter int DEF_LEN = DEFAULT_LEN,
  parameter bit DEFAULT_OVERLAP = 1'b1,
  parameter int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LW-1:0]      cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               x_valid_i,
  input  logic               x_i,
  input  logic               cnt_clr_i,
  output logic               det_o,
  output logic [CNT_W-1:0]   det_cnt_o,
  output logic [LW-1:0]      cfg_len_o
);
  logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
  logic [LW-1:0]      fill_q, fill_d, len_q, len_d;
  logic               ovl_q, ovl_d, det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, match;
  // a config load takes priority over the data strobe in the same cycle
  assign accept = x_valid_i & ~cfg_we_i;
  seq_match #(.MAX_LEN(MAX_LEN), .LW(LW)) u_match (
    .hist_i   (hist_q),
    .x_i      (x_i),
    .valid_i  (accept),
    .pattern_i(pat_q),
    .len_i    (len_q),
    .fill_i   (fill_q),
    .match_o  (match)
  );
  always_comb begin
    pat_d  = cfg_we_i ? cfg_pattern_i : pat_q;
    len_d  = !cfg_we_i ? len_q : (cfg_len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len_i;
    ovl_d  = cfg_we_i ? cfg_overlap_i : ovl_q;
    hist_d = cfg_we_i ? '0 : accept ? {hist_q[MAX_LEN-2:0], x_i} : hist_q;
    fill_d = cfg_we_i ? '0 :
             !accept ? fill_q :
             (match && !ovl_q) ? '0 :
             (fill_q < len_q) ? fill_q + LW'(1) : fill_q;
    det_d  = match;
    cnt_d  = cnt_clr_i ? CNT_W'(match) :
             (match && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LW'(DEF_LEN);
      ovl_q  <= DEFAULT_OVERLAP;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end
  assign det_o     = det_q;
  assign det_cnt_o = cnt_q;
  assign cfg_len_o = len_q;
endmodule
